// File: rtl/qam_pkg.sv
// Shared definitions for the QAM transmit path: baud rate codes, the rate-to-upsample
// factor map and the symbol scheduler state encoding.
package qam_pkg;

    localparam logic [1:0] BAUD_9600  = 2'b00;
    localparam logic [1:0] BAUD_19200 = 2'b01;
    localparam logic [1:0] BAUD_38400 = 2'b10;
    localparam logic [1:0] BAUD_76800 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // Filter-clock cycles per symbol for each rate code (76800 / baud).
    function automatic logic [3:0] baud_to_n(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            BAUD_9600:  n = 4'd8;
            BAUD_19200: n = 4'd4;
            BAUD_38400: n = 4'd2;
            BAUD_76800: n = 4'd1;
            default:    n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/upsamp_phase_ctr.sv
// Symbol-period phase counter: counts 0..N-1 while running, latching N only at period start.
// Flags are combinational from registers; no backpressure, advances every cycle outside IDLE.
module upsamp_phase_ctr
    import qam_pkg::*;
(
    input  logic         clk_76800,
    input  logic         rst_n,
    input  sched_state_t state_i,
    input  logic         en_i,
    input  logic [1:0]   baud_rate_i,
    output logic         boundary_o,
    output logic         last_o
);

    logic [2:0] phase_q, phase_d;
    logic [3:0] n_cur_q, n_cur_d;

    assign last_o     = ({1'b0, phase_q} == (n_cur_q - 4'd1));
    assign boundary_o = (state_i == ST_RUN) && (phase_q == 3'd0);

    // Rate changes are only sampled at a wrap, so a period never changes length mid-way.
    always_comb begin
        phase_d = phase_q;
        n_cur_d = n_cur_q;
        if (state_i == ST_IDLE) begin
            phase_d = 3'd0;
            if (en_i) begin
                n_cur_d = baud_to_n(baud_rate_i);
            end
        end else if (last_o) begin
            phase_d = 3'd0;
            n_cur_d = baud_to_n(baud_rate_i);
        end else begin
            phase_d = phase_q + 3'd1;
        end
    end

    always_ff @(posedge clk_76800 or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 3'd0;
            n_cur_q <= 4'd8;
        end else begin
            phase_q <= phase_d;
            n_cur_q <= n_cur_d;
        end
    end

endmodule

// File: rtl/upsamp_sched.sv
// Symbol scheduler/upsampler: pulls one I/Q symbol per period, emits one sample per clk_76800.
// Latency: symbol accepted in cycle t appears with up_first in t+1; sym_ready is only high at RUN phase 0.
module upsamp_sched
    import qam_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit HOLD  = 1'b1
)
(
    input  logic             clk_76800,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       baud_rate,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [WIDTH-1:0] sym_i,
    input  logic [WIDTH-1:0] sym_q,
    output logic [WIDTH-1:0] up_i,
    output logic [WIDTH-1:0] up_q,
    output logic             up_first,
    output logic             busy,
    output logic             underrun,
    input  logic             underrun_clr
);

    sched_state_t     state_q;
    logic [WIDTH-1:0] hold_i_q, hold_q_q;
    logic [WIDTH-1:0] up_i_q, up_q_q;
    logic             up_first_q, underrun_q;
    logic             boundary, last;
    logic [WIDTH-1:0] cap_i, cap_q;

    upsamp_phase_ctr u_phase_ctr (
        .clk_76800   (clk_76800),
        .rst_n       (rst_n),
        .state_i     (state_q),
        .en_i        (en),
        .baud_rate_i (baud_rate),
        .boundary_o  (boundary),
        .last_o      (last)
    );

    // An empty boundary plays out a period of zeros rather than stalling the filter.
    assign cap_i = sym_valid ? sym_i : '0;
    assign cap_q = sym_valid ? sym_q : '0;

    always_ff @(posedge clk_76800 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_i_q   <= '0;
            hold_q_q   <= '0;
            up_i_q     <= '0;
            up_q_q     <= '0;
            up_first_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (boundary && !sym_valid) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    up_i_q     <= '0;
                    up_q_q     <= '0;
                    up_first_q <= 1'b0;
                    if (en) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (boundary) begin
                        hold_i_q   <= cap_i;
                        hold_q_q   <= cap_q;
                        up_i_q     <= cap_i;
                        up_q_q     <= cap_q;
                        up_first_q <= 1'b1;
                    end else begin
                        up_i_q     <= HOLD ? hold_i_q : '0;
                        up_q_q     <= HOLD ? hold_q_q : '0;
                        up_first_q <= 1'b0;
                    end
                    // Disabling on the final phase completes the period here; DRAIN would open a new one.
                    if (!en) begin
                        state_q <= last ? ST_IDLE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    up_i_q     <= HOLD ? hold_i_q : '0;
                    up_q_q     <= HOLD ? hold_q_q : '0;
                    up_first_q <= 1'b0;
                    if (en) begin
                        state_q <= ST_RUN;
                    end else if (last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sym_ready = boundary;
    assign up_i      = up_i_q;
    assign up_q      = up_q_q;
    assign up_first  = up_first_q;
    assign busy      = (state_q != ST_IDLE);
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_upsamp_sched.sv
// Bench for upsamp_sched: zero-stuff and sample-hold instances share stimulus; a period scoreboard
// is filled at each expected boundary and drained one entry per output cycle.
module tb_upsamp_sched;

    localparam int W = 32;

    logic clk_76800 = 1'b0;
    always #5 clk_76800 = ~clk_76800;

    logic         rst_n, en, sym_valid, underrun_clr;
    logic [1:0]   baud_rate;
    logic [W-1:0] sym_i, sym_q;

    logic [W-1:0] zs_up_i, zs_up_q, sh_up_i, sh_up_q;
    logic         zs_first, zs_rdy, zs_busy, zs_und;
    logic         sh_first, sh_rdy, sh_busy, sh_und;

    upsamp_sched #(.WIDTH(W), .HOLD(1'b0)) dut_zs (
        .clk_76800 (clk_76800), .rst_n (rst_n), .en (en), .baud_rate (baud_rate),
        .sym_valid (sym_valid), .sym_ready (zs_rdy), .sym_i (sym_i), .sym_q (sym_q),
        .up_i (zs_up_i), .up_q (zs_up_q), .up_first (zs_first), .busy (zs_busy),
        .underrun (zs_und), .underrun_clr (underrun_clr)
    );

    upsamp_sched #(.WIDTH(W), .HOLD(1'b1)) dut_sh (
        .clk_76800 (clk_76800), .rst_n (rst_n), .en (en), .baud_rate (baud_rate),
        .sym_valid (sym_valid), .sym_ready (sh_rdy), .sym_i (sym_i), .sym_q (sym_q),
        .up_i (sh_up_i), .up_q (sh_up_q), .up_first (sh_first), .busy (sh_busy),
        .underrun (sh_und), .underrun_clr (underrun_clr)
    );

    typedef struct packed {
        logic [W-1:0] i0, q0, i1, q1;
        logic         first;
    } sb_t;

    typedef struct {
        logic       en;
        logic [1:0] baud;
        logic       vld;
        logic       clr;
        int         seed;
        int         ncyc;
        int         exp_acc;
    } row_t;

    sb_t          sb_q[$];
    row_t         rows[21];
    int           tests = 0;
    int           fails = 0;
    int           acc;
    logic [W-1:0] nxt;
    logic         exp_und;
    logic         rdy;

    function automatic int n_of(input logic [1:0] b);
        case (b)
            2'b00:   return 8;
            2'b01:   return 4;
            2'b10:   return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: inputs still hold the values the last posedge saw.
    task automatic check_cycle(output logic exp_rdy);
        sb_t  e;
        logic exp_busy;
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        exp_rdy  = en && (sb_q.size() == 0);
        exp_busy = en || (sb_q.size() != 0);
        chk("zs_up_i", zs_up_i, e.i0);
        chk("zs_up_q", zs_up_q, e.q0);
        chk("zs_first", zs_first, e.first);
        chk("sh_up_i", sh_up_i, e.i1);
        chk("sh_up_q", sh_up_q, e.q1);
        chk("sh_first", sh_first, e.first);
        chk("zs_sym_ready", zs_rdy, exp_rdy);
        chk("sh_sym_ready", sh_rdy, exp_rdy);
        chk("zs_busy", zs_busy, exp_busy);
        chk("sh_busy", sh_busy, exp_busy);
        chk("zs_underrun", zs_und, exp_und);
        chk("sh_underrun", sh_und, exp_und);
    endtask

    task automatic apply(input row_t r, input logic exp_rdy);
        int           n;
        sb_t          e;
        logic [W-1:0] vi, vq;
        n            = n_of(baud_rate);
        en           = r.en;
        baud_rate    = r.baud;
        sym_valid    = r.vld;
        underrun_clr = r.clr;
        sym_i        = nxt;
        sym_q        = -nxt;
        if (zs_rdy && sym_valid) acc++;
        if (exp_rdy) begin
            vi = r.vld ? nxt : '0;
            vq = r.vld ? -nxt : '0;
            for (int p = 0; p < n; p++) begin
                e.first = (p == 0);
                e.i0    = (p == 0) ? vi : '0;
                e.q0    = (p == 0) ? vq : '0;
                e.i1    = vi;
                e.q1    = vq;
                sb_q.push_back(e);
            end
            if (r.vld) nxt = nxt + 2;
        end
        if (exp_rdy && !r.vld) exp_und = 1'b1;
        else if (r.clr)        exp_und = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (rows[i].seed != 0) nxt = rows[i].seed;
            acc = 0;
            for (int c = 0; c < rows[i].ncyc; c++) begin
                check_cycle(rdy);
                apply(rows[i], rdy);
                @(negedge clk_76800);
            end
            chk($sformatf("row%0d_accepts", i), acc, rows[i].exp_acc);
        end
    endtask

    initial begin
        //        en  baud  vld   clr  seed ncyc acc
        rows[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 5, 24, 3};  // 9600, continuous symbols
        rows[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 0,  4, 1};
        rows[2]  = '{1'b1, 2'd1, 1'b1, 1'b0, 0, 12, 2};  // rate change at phase 3
        rows[3]  = '{1'b1, 2'd1, 1'b0, 1'b0, 0,  2, 0};  // underrun at boundary
        rows[4]  = '{1'b1, 2'd1, 1'b1, 1'b0, 0,  4, 1};
        rows[5]  = '{1'b1, 2'd1, 1'b1, 1'b1, 0,  1, 0};  // clear pulse
        rows[6]  = '{1'b1, 2'd1, 1'b1, 1'b0, 0,  2, 0};
        rows[7]  = '{1'b1, 2'd1, 1'b0, 1'b1, 0,  1, 0};  // clear and underrun together
        rows[8]  = '{1'b1, 2'd1, 1'b1, 1'b0, 0,  5, 1};
        rows[9]  = '{1'b1, 2'd0, 1'b1, 1'b1, 0,  1, 0};
        rows[10] = '{1'b1, 2'd0, 1'b1, 1'b0, 0,  3, 1};
        rows[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 0,  8, 0};  // disable at phase 2, drain
        rows[12] = '{1'b1, 2'd0, 1'b1, 1'b0, 0,  4, 1};
        rows[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 0,  2, 0};  // short drain
        rows[14] = '{1'b1, 2'd0, 1'b1, 1'b0, 0,  6, 1};  // re-enable inside drain
        rows[15] = '{1'b1, 2'd3, 1'b1, 1'b0, 0, 14, 9};  // 76800: symbol per clock
        rows[16] = '{1'b1, 2'd2, 1'b1, 1'b0, 3,  4, 3};  // 38400 sample-hold
        rows[17] = '{1'b1, 2'd2, 1'b0, 1'b0, 0,  2, 0};
        rows[18] = '{1'b1, 2'd0, 1'b1, 1'b0, 0,  6, 1};  // stop at phase 5 of an N=8 period
        rows[19] = '{1'b1, 2'd1, 1'b1, 1'b0, 0,  7, 2};
        rows[20] = '{1'b0, 2'd1, 1'b1, 1'b0, 0,  6, 0};

        rst_n        = 1'b0;
        en           = 1'b0;
        baud_rate    = 2'd0;
        sym_valid    = 1'b0;
        underrun_clr = 1'b0;
        sym_i        = '0;
        sym_q        = '0;
        nxt          = '0;
        exp_und      = 1'b0;

        repeat (2) @(negedge clk_76800);
        check_cycle(rdy);
        #2 rst_n = 1'b1;
        @(negedge clk_76800);

        run_rows(0, 18);

        // Asynchronous reset mid-period: outputs must clear without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_zs_up_i", zs_up_i, '0);
        chk("rst_sh_up_i", sh_up_i, '0);
        chk("rst_sh_up_q", sh_up_q, '0);
        chk("rst_zs_first", zs_first, 1'b0);
        chk("rst_sym_ready", sh_rdy, 1'b0);
        chk("rst_busy", sh_busy, 1'b0);
        chk("rst_underrun", sh_und, 1'b0);
        sb_q.delete();
        exp_und   = 1'b0;
        en        = 1'b0;
        sym_valid = 1'b0;
        @(negedge clk_76800);
        #2 rst_n = 1'b1;
        @(negedge clk_76800);

        run_rows(19, 20);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
